// File: rtl/id_ex_stage_if.sv
// Signal bundle between decode/downstream control (master) and the ID/EX stage (slave).
interface id_ex_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
);
  logic          in_valid;
  logic [2:0]    in_op;
  logic [AW-1:0] in_rs1_addr;
  logic [AW-1:0] in_rs2_addr;
  logic [DW-1:0] in_rs1_data;
  logic [DW-1:0] in_rs2_data;
  logic [DW-1:0] in_imm;
  logic          in_use_imm;
  logic [AW-1:0] in_rd_addr;
  logic          in_wen;
  logic          ex_stall;
  logic          flush;
  logic          exm_wen;
  logic [AW-1:0] exm_rd;
  logic [DW-1:0] exm_data;
  logic          mwb_wen;
  logic [AW-1:0] mwb_rd;
  logic [DW-1:0] mwb_data;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic          out_valid;
  logic [AW-1:0] out_rd;
  logic          out_wen;
  logic          hazard_stall;

  modport master (
    output in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd_addr, in_wen, ex_stall, flush,
           exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data,
    input  alu_a, alu_b, alu_op, out_valid, out_rd, out_wen, hazard_stall
  );

  modport slave (
    input  in_valid, in_op, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_use_imm, in_rd_addr, in_wen, ex_stall, flush,
           exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data,
    output alu_a, alu_b, alu_op, out_valid, out_rd, out_wen, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand select. Define ID_EX_FWD_EN to build
// EX/MEM and MEM/WB forwarding; otherwise RAW hazards interlock via hazard_stall.
module id_ex_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic          valid_q, valid_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
  logic [DW-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
  logic          use_imm_q, use_imm_d;
  logic          wen_q, wen_d;
  logic          capture;
  logic          load;
  logic [DW-1:0] src_a, src_b;

`ifdef ID_EX_FWD_EN
  function automatic logic [DW-1:0] pick(input logic [AW-1:0] addr,
                                          input logic [DW-1:0] reg_data,
                                          input logic exm_wen, input logic [AW-1:0] exm_rd,
                                          input logic [DW-1:0] exm_data,
                                          input logic mwb_wen, input logic [AW-1:0] mwb_rd,
                                          input logic [DW-1:0] mwb_data);
    if (addr == '0)                          return '0;
    else if (exm_wen && (exm_rd == addr))    return exm_data;
    else if (mwb_wen && (mwb_rd == addr))    return mwb_data;
    else                                     return reg_data;
  endfunction

  assign src_a = pick(rs1_addr_q, rs1_data_q, bus.exm_wen, bus.exm_rd, bus.exm_data,
                      bus.mwb_wen, bus.mwb_rd, bus.mwb_data);
  assign src_b = pick(rs2_addr_q, rs2_data_q, bus.exm_wen, bus.exm_rd, bus.exm_data,
                      bus.mwb_wen, bus.mwb_rd, bus.mwb_data);
  assign bus.hazard_stall = 1'b0;
`else
  function automatic logic busy(input logic [AW-1:0] addr,
                                input logic st_wen, input logic [AW-1:0] st_rd,
                                input logic exm_wen, input logic [AW-1:0] exm_rd,
                                input logic mwb_wen, input logic [AW-1:0] mwb_rd);
    return (addr != '0) &&
           ((st_wen && (st_rd == addr)) ||
            (exm_wen && (exm_rd == addr)) ||
            (mwb_wen && (mwb_rd == addr)));
  endfunction

  assign src_a = (rs1_addr_q == '0) ? '0 : rs1_data_q;
  assign src_b = (rs2_addr_q == '0) ? '0 : rs2_data_q;
  // Register file is not write-through, so a pending MEM/WB write also stalls.
  assign bus.hazard_stall = rst_n && bus.in_valid &&
    (busy(bus.in_rs1_addr, valid_q && wen_q, rd_q, bus.exm_wen, bus.exm_rd,
          bus.mwb_wen, bus.mwb_rd) ||
     (!bus.in_use_imm &&
      busy(bus.in_rs2_addr, valid_q && wen_q, rd_q, bus.exm_wen, bus.exm_rd,
           bus.mwb_wen, bus.mwb_rd)));
`endif

  assign capture = bus.flush || !bus.ex_stall;
  assign load    = !bus.flush && !bus.hazard_stall && bus.in_valid;

  always_comb begin
    valid_d    = '0;
    op_d       = '0;
    rs1_addr_d = '0;
    rs2_addr_d = '0;
    rs1_data_d = '0;
    rs2_data_d = '0;
    imm_d      = '0;
    use_imm_d  = '0;
    rd_d       = '0;
    wen_d      = '0;
    if (load) begin
      valid_d    = 1'b1;
      op_d       = bus.in_op;
      rs1_addr_d = bus.in_rs1_addr;
      rs2_addr_d = bus.in_rs2_addr;
      rs1_data_d = bus.in_rs1_data;
      rs2_data_d = bus.in_rs2_data;
      imm_d      = bus.in_imm;
      use_imm_d  = bus.in_use_imm;
      rd_d       = bus.in_rd_addr;
      wen_d      = bus.in_wen;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      op_q       <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      use_imm_q  <= '0;
      rd_q       <= '0;
      wen_q      <= '0;
    end else if (capture) begin
      valid_q    <= valid_d;
      op_q       <= op_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      use_imm_q  <= use_imm_d;
      rd_q       <= rd_d;
      wen_q      <= wen_d;
    end
  end

  always_comb begin
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_op    = '0;
    bus.out_valid = valid_q;
    bus.out_rd    = rd_q;
    bus.out_wen   = valid_q && wen_q;
    if (valid_q) begin
      bus.alu_a  = src_a;
      bus.alu_b  = use_imm_q ? imm_q : src_b;
      bus.alu_op = op_q;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; forwarding or interlock scenarios
// are selected by ID_EX_FWD_EN to match the build under test.
module tb_id_ex_stage;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_XOR = 3'd3,
                         OP_MUL = 3'd5, OP_ADDI = 3'd6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  id_ex_stage_if #(.DW(16), .AW(4)) bus ();
  id_ex_stage #(.DW(16), .AW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.in_op = '0; bus.in_rs1_addr = '0; bus.in_rs2_addr = '0;
    bus.in_rs1_data = '0; bus.in_rs2_data = '0; bus.in_imm = '0; bus.in_use_imm = 0;
    bus.in_rd_addr = '0; bus.in_wen = 0; bus.ex_stall = 0; bus.flush = 0;
    bus.exm_wen = 0; bus.exm_rd = '0; bus.exm_data = '0;
    bus.mwb_wen = 0; bus.mwb_rd = '0; bus.mwb_data = '0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] rs1, input logic [15:0] d1,
                       input logic [3:0] rs2, input logic [15:0] d2, input logic [15:0] imm,
                       input logic use_imm, input logic [3:0] rd, input logic wen);
    bus.in_valid = 1; bus.in_op = op; bus.in_rs1_addr = rs1; bus.in_rs1_data = d1;
    bus.in_rs2_addr = rs2; bus.in_rs2_data = d2; bus.in_imm = imm;
    bus.in_use_imm = use_imm; bus.in_rd_addr = rd; bus.in_wen = wen;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    issue(OP_ADD, 4'd1, 16'h0005, 4'd2, 16'h0007, 16'h0000, 0, 4'd5, 1);
    bus.exm_wen = 1; bus.exm_rd = 4'd1;
    step(); step();
    checks++; if (bus.alu_a !== 16'h0) begin errors++; $display("FAIL rst_alu_a got %h exp 0000", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0) begin errors++; $display("FAIL rst_alu_b got %h exp 0000", bus.alu_b); end
    checks++; if (bus.alu_op !== 3'd0) begin errors++; $display("FAIL rst_alu_op got %0d exp 0", bus.alu_op); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_wen !== 1'b0 || bus.out_rd !== 4'd0)
      begin errors++; $display("FAIL rst_out got v%b w%b rd%0d exp 0 0 0", bus.out_valid, bus.out_wen, bus.out_rd); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b exp 0", bus.hazard_stall); end
    bus.exm_wen = 0;
    rst_n = 1;
    step();
    checks++; if (bus.alu_a !== 16'h0005) begin errors++; $display("FAIL add_alu_a got %h exp 0005", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0007) begin errors++; $display("FAIL add_alu_b got %h exp 0007", bus.alu_b); end
    checks++; if (bus.alu_op !== OP_ADD) begin errors++; $display("FAIL add_alu_op got %0d exp %0d", bus.alu_op, OP_ADD); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_wen !== 1'b1 || bus.out_rd !== 4'd5)
      begin errors++; $display("FAIL add_out got v%b w%b rd%0d exp 1 1 5", bus.out_valid, bus.out_wen, bus.out_rd); end
  endtask

  task automatic test_r0_imm();
    idle();
    issue(OP_ADDI, 4'd0, 16'h1234, 4'd4, 16'h9999, 16'h0010, 1, 4'd6, 1);
    bus.exm_wen = 1; bus.exm_rd = 4'd0; bus.exm_data = 16'hFFFF;
    #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL r0imm_hazard got %b exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.alu_a !== 16'h0000) begin errors++; $display("FAIL r0imm_alu_a got %h exp 0000", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0010) begin errors++; $display("FAIL r0imm_alu_b got %h exp 0010", bus.alu_b); end
    checks++; if (bus.alu_op !== OP_ADDI) begin errors++; $display("FAIL r0imm_alu_op got %0d exp %0d", bus.alu_op, OP_ADDI); end
    idle();
    step();
  endtask

`ifdef ID_EX_FWD_EN
  task automatic test_forwarding();
    idle();
    issue(OP_SUB, 4'd3, 16'h0001, 4'd2, 16'h0002, 16'h0000, 0, 4'd9, 1);
    step();
    idle();
    bus.exm_wen = 1; bus.exm_rd = 4'd3; bus.exm_data = 16'h00AA;
    bus.mwb_wen = 1; bus.mwb_rd = 4'd3; bus.mwb_data = 16'h0055;
    #1;
    checks++; if (bus.alu_a !== 16'h00AA) begin errors++; $display("FAIL fwd_exm_a got %h exp 00aa", bus.alu_a); end
    checks++; if (bus.alu_b !== 16'h0002) begin errors++; $display("FAIL fwd_nomatch_b got %h exp 0002", bus.alu_b); end
    bus.exm_wen = 0; #1;
    checks++; if (bus.alu_a !== 16'h0055) begin errors++; $display("FAIL fwd_mwb_a got %h exp 0055", bus.alu_a); end
    bus.mwb_wen = 0; #1;
    checks++; if (bus.alu_a !== 16'h0001) begin errors++; $display("FAIL fwd_reg_a got %h exp 0001", bus.alu_a); end
    bus.exm_wen = 1; bus.exm_rd = 4'd2; #1;
    checks++; if (bus.alu_b !== 16'h00AA) begin errors++; $display("FAIL fwd_exm_b got %h exp 00aa", bus.alu_b); end
    issue(OP_XOR, 4'd9, 16'h0000, 4'd2, 16'h0000, 16'h0000, 0, 4'd1, 1); #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL fwd_hazard got %b exp 0", bus.hazard_stall); end
    idle();
    step();
  endtask
`else
  task automatic test_interlock();
    idle();
    issue(OP_ADD, 4'd1, 16'h0003, 4'd2, 16'h0004, 16'h0000, 0, 4'd4, 1);
    step();
    issue(OP_XOR, 4'd4, 16'h0F0F, 4'd6, 16'h00F0, 16'h0000, 0, 4'd7, 1);
    #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL ilk_stage_hazard got %b exp 1", bus.hazard_stall); end
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_wen !== 1'b0 || bus.alu_op !== 3'd0)
      begin errors++; $display("FAIL ilk_bubble1 got v%b w%b op%0d exp 0 0 0", bus.out_valid, bus.out_wen, bus.alu_op); end
    bus.exm_wen = 1; bus.exm_rd = 4'd4; #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL ilk_exm_hazard got %b exp 1", bus.hazard_stall); end
    step();
    bus.exm_wen = 0; bus.mwb_wen = 1; bus.mwb_rd = 4'd4; #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL ilk_mwb_hazard got %b exp 1", bus.hazard_stall); end
    step();
    checks++; if (bus.out_wen !== 1'b0) begin errors++; $display("FAIL ilk_bubble3 got w%b exp 0", bus.out_wen); end
    bus.mwb_wen = 0; bus.in_rs1_data = 16'h0007; #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL ilk_clear got %b exp 0", bus.hazard_stall); end
    step();
    checks++; if (bus.alu_a !== 16'h0007 || bus.alu_b !== 16'h00F0)
      begin errors++; $display("FAIL ilk_xor_ops got a%h b%h exp a0007 b00f0", bus.alu_a, bus.alu_b); end
    checks++; if (bus.alu_op !== OP_XOR || bus.out_valid !== 1'b1 || bus.out_rd !== 4'd7)
      begin errors++; $display("FAIL ilk_xor_ctl got op%0d v%b rd%0d exp 3 1 7", bus.alu_op, bus.out_valid, bus.out_rd); end
    issue(OP_ADDI, 4'd1, 16'h0000, 4'd7, 16'h0000, 16'h0001, 1, 4'd2, 1); #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL ilk_imm_rs2 got %b exp 0", bus.hazard_stall); end
    bus.in_use_imm = 0; #1;
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL ilk_rs2 got %b exp 1", bus.hazard_stall); end
    bus.in_valid = 0; #1;
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL ilk_novalid got %b exp 0", bus.hazard_stall); end
    idle();
    step();
  endtask
`endif

  task automatic test_stall_flush();
    idle();
    issue(OP_MUL, 4'd1, 16'h0003, 4'd2, 16'h0004, 16'h0000, 0, 4'd8, 1);
    step();
    issue(OP_ADD, 4'd1, 16'h1111, 4'd2, 16'h2222, 16'h0000, 0, 4'd9, 1);
    bus.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.alu_a !== 16'h0003 || bus.alu_b !== 16'h0004 || bus.alu_op !== OP_MUL ||
          bus.out_valid !== 1'b1 || bus.out_wen !== 1'b1 || bus.out_rd !== 4'd8)
        begin errors++; $display("FAIL hold%0d got a%h b%h op%0d v%b w%b rd%0d exp a0003 b0004 op5 v1 w1 rd8",
                                 i, bus.alu_a, bus.alu_b, bus.alu_op, bus.out_valid, bus.out_wen, bus.out_rd); end
    end
    bus.flush = 1;
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_wen !== 1'b0 || bus.alu_op !== 3'd0 || bus.alu_a !== 16'h0)
      begin errors++; $display("FAIL flush got v%b w%b op%0d a%h exp 0 0 0 0000", bus.out_valid, bus.out_wen, bus.alu_op, bus.alu_a); end
    bus.flush = 0; bus.ex_stall = 0;
    step();
    checks++; if (bus.alu_a !== 16'h1111 || bus.alu_b !== 16'h2222 || bus.out_rd !== 4'd9)
      begin errors++; $display("FAIL after_flush got a%h b%h rd%0d exp a1111 b2222 rd9", bus.alu_a, bus.alu_b, bus.out_rd); end
  endtask

  task automatic test_reset_midop();
    #2;
    rst_n = 0;
    #1;
    checks++; if (bus.out_wen !== 1'b0 || bus.out_valid !== 1'b0 || bus.alu_a !== 16'h0)
      begin errors++; $display("FAIL midrst got w%b v%b a%h exp 0 0 0000", bus.out_wen, bus.out_valid, bus.alu_a); end
    idle();
    step();
    rst_n = 1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got v%b exp 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_r0_imm();
`ifdef ID_EX_FWD_EN
    test_forwarding();
`else
    test_interlock();
`endif
    test_stall_flush();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
